// File: rtl/ex_div_if.sv
// Handshake and operand/result bundle between the EX pipeline and the divider.
// The pipeline side is master, the divider is slave.
interface ex_div_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] div_src1;
  logic [WIDTH-1:0] div_src2;
  logic             div_flush;
  logic             div_stall;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport master (
    output div_start, div_signed, div_src1, div_src2, div_flush,
    input  div_stall, div_done, div_quotient, div_remainder
  );

  modport slave (
    input  div_start, div_signed, div_src1, div_src2, div_flush,
    output div_stall, div_done, div_quotient, div_remainder
  );
endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Quotient feeds LO, remainder feeds HI.
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  ex_div_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw1_q, raw1_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             rst_mask_q;

  logic             s1, s2, accept;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step, mag1, mag2;

  assign s1     = bus.div_signed & bus.div_src1[WIDTH-1];
  assign s2     = bus.div_signed & bus.div_src2[WIDTH-1];
  assign mag1   = s1 ? -bus.div_src1 : bus.div_src1;
  assign mag2   = s2 ? -bus.div_src2 : bus.div_src2;
  // The cycle right after reset neither stalls nor accepts.
  assign accept = (state_q == IDLE) & bus.div_start & ~bus.div_flush & ~rst_mask_q;

  // Dividend bits stream out of quo_q's MSB while quotient bits enter at its LSB.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    raw1_d      = raw1_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = mag1;
          dvs_d   = mag2;
          raw1_d  = bus.div_src1;
          q_neg_d = s1 ^ s2;
          r_neg_d = s1;
          dbz_d   = (bus.div_src2 == '0);
        end
      end
      CALC: begin
        if (bus.div_flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            // Overflow (most-negative / -1) falls out of the magnitude path unaided.
            if (dbz_q) begin
              quotient_d  = '1;
              remainder_d = raw1_q;
            end else begin
              quotient_d  = q_neg_q ? -quo_step : quo_step;
              remainder_d = r_neg_q ? -rem_step : rem_step;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      raw1_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      rst_mask_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      raw1_q      <= raw1_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      rst_mask_q  <= 1'b0;
    end
  end

  assign bus.div_stall     = accept | ((state_q == CALC) & ~bus.div_flush);
  assign bus.div_done      = done_q;
  assign bus.div_quotient  = quotient_q;
  assign bus.div_remainder = remainder_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed-vector bench for ex_div_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, flush, mid-op reset and back-to-back divides.
module tb_ex_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  ex_div_if #(.WIDTH(32)) bus ();

  ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drives one divide from the next cycle and reports latency, stall count and result.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r,
                         output int lat, output int stall_cnt, output logic stall_at_done);
    @(posedge clk); #1;
    bus.div_src1 = a; bus.div_src2 = b; bus.div_signed = sgn; bus.div_start = 1'b1;
    #1;
    lat = -1; stall_cnt = 0; stall_at_done = 1'bx; q = 'x; r = 'x;
    for (int c = 0; c < 60; c++) begin
      if (bus.div_done) begin
        lat = c; stall_at_done = bus.div_stall;
        q = bus.div_quotient; r = bus.div_remainder;
        break;
      end
      if (bus.div_stall) stall_cnt++;
      @(posedge clk); #2;
    end
    @(posedge clk); #1;
    bus.div_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.div_start = 1'b0; bus.div_signed = 1'b0; bus.div_flush = 1'b0;
    bus.div_src1 = '0; bus.div_src2 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_chk++; if (bus.div_quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quotient: got %h expected %h", bus.div_quotient, 32'h0); end
    n_chk++; if (bus.div_remainder !== 32'h0) begin n_fail++; $display("FAIL reset_remainder: got %h expected %h", bus.div_remainder, 32'h0); end
    n_chk++; if (bus.div_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.div_done); end
    n_chk++; if (bus.div_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.div_stall); end
  endtask

  task automatic test_divu_basic();
    logic [31:0] q, r; int lat, sc; logic sd;
    run_div(32'd100, 32'd7, 1'b0, q, r, lat, sc, sd);
    n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    n_chk++; if (sc !== 33) begin n_fail++; $display("FAIL divu_stall_cycles: got %0d expected 33", sc); end
    n_chk++; if (sd !== 1'b0) begin n_fail++; $display("FAIL divu_stall_at_done: got %b expected 0", sd); end
    n_chk++; if (q !== 32'd14) begin n_fail++; $display("FAIL divu_quotient: got %h expected %h", q, 32'd14); end
    n_chk++; if (r !== 32'd2) begin n_fail++; $display("FAIL divu_remainder: got %h expected %h", r, 32'd2); end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; int lat, sc; logic sd;
    run_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, q, r, lat, sc, sd);
    n_chk++; if (q !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg7_2_q: got %h expected %h", q, 32'hFFFF_FFFD); end
    n_chk++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg7_2_r: got %h expected %h", r, 32'hFFFF_FFFF); end
    run_div(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, q, r, lat, sc, sd);
    n_chk++; if (q !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_neg2_q: got %h expected %h", q, 32'hFFFF_FFFD); end
    n_chk++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL div_7_neg2_r: got %h expected %h", r, 32'h0000_0001); end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; int lat, sc; logic sd;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat, sc, sd);
    n_chk++; if (q !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_q: got %h expected %h", q, 32'h8000_0000); end
    n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL div_ovf_r: got %h expected %h", r, 32'h0); end
    run_div(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, q, r, lat, sc, sd);
    n_chk++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_max_q: got %h expected %h", q, 32'hFFFF_FFFF); end
    n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL divu_max_r: got %h expected %h", r, 32'h0); end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; int lat, sc; logic sd;
    run_div(32'd5, 32'd0, 1'b0, q, r, lat, sc, sd);
    n_chk++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_dz_q: got %h expected %h", q, 32'hFFFF_FFFF); end
    n_chk++; if (r !== 32'h0000_0005) begin n_fail++; $display("FAIL divu_dz_r: got %h expected %h", r, 32'h0000_0005); end
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, q, r, lat, sc, sd);
    n_chk++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_dz_q: got %h expected %h", q, 32'hFFFF_FFFF); end
    n_chk++; if (r !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL div_dz_r: got %h expected %h", r, 32'hFFFF_FFFB); end
  endtask

  // Relies on the preceding divide-by-zero case having left q=FFFFFFFF, r=FFFFFFFB.
  task automatic test_flush();
    logic [31:0] q, r; int lat, sc; logic sd; logic got_done;
    got_done = 1'b0;
    @(posedge clk); #1;
    bus.div_src1 = 32'd100; bus.div_src2 = 32'd7; bus.div_signed = 1'b0; bus.div_start = 1'b1;
    #1;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #2;
      if (bus.div_done) got_done = 1'b1;
    end
    @(posedge clk); #1 bus.div_flush = 1'b1; #1;
    n_chk++; if (bus.div_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", bus.div_stall); end
    n_chk++; if (bus.div_done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b expected 0", bus.div_done); end
    @(posedge clk); #1 bus.div_flush = 1'b0; bus.div_start = 1'b0; #1;
    if (bus.div_done) got_done = 1'b1;
    n_chk++; if (got_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", got_done); end
    n_chk++; if (bus.div_stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b expected 0", bus.div_stall); end
    n_chk++; if (bus.div_quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_q_held: got %h expected %h", bus.div_quotient, 32'hFFFF_FFFF); end
    n_chk++; if (bus.div_remainder !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL flush_r_held: got %h expected %h", bus.div_remainder, 32'hFFFF_FFFB); end
    run_div(32'd9, 32'd3, 1'b0, q, r, lat, sc, sd);
    n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL post_flush_latency: got %0d expected 33", lat); end
    n_chk++; if (q !== 32'd3) begin n_fail++; $display("FAIL post_flush_q: got %h expected %h", q, 32'd3); end
    n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL post_flush_r: got %h expected %h", r, 32'd0); end
  endtask

  task automatic test_reset_mid();
    int extra_done;
    extra_done = 0;
    @(posedge clk); #1;
    bus.div_src1 = 32'd50; bus.div_src2 = 32'd7; bus.div_signed = 1'b0; bus.div_start = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; bus.div_start = 1'b0;
    @(posedge clk); #1 rst = 1'b0; #1;
    n_chk++; if (bus.div_quotient !== 32'h0) begin n_fail++; $display("FAIL rstmid_q: got %h expected %h", bus.div_quotient, 32'h0); end
    n_chk++; if (bus.div_remainder !== 32'h0) begin n_fail++; $display("FAIL rstmid_r: got %h expected %h", bus.div_remainder, 32'h0); end
    n_chk++; if (bus.div_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", bus.div_stall); end
    for (int c = 0; c < 40; c++) begin
      if (bus.div_done) extra_done++;
      @(posedge clk); #2;
    end
    n_chk++; if (extra_done !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", extra_done); end
  endtask

  task automatic test_back_to_back();
    int first, second, ndone;
    logic [31:0] q1, r1, q2, r2;
    logic stall_acc;
    first = -1; second = -1; ndone = 0; stall_acc = 1'bx;
    q1 = 'x; r1 = 'x; q2 = 'x; r2 = 'x;
    @(posedge clk); #1;
    bus.div_src1 = 32'd20; bus.div_src2 = 32'd3; bus.div_signed = 1'b0; bus.div_start = 1'b1;
    #1;
    for (int c = 0; c < 90; c++) begin
      if (bus.div_done) begin
        ndone++;
        if (first < 0) begin first = c; q1 = bus.div_quotient; r1 = bus.div_remainder; end
        else begin second = c; q2 = bus.div_quotient; r2 = bus.div_remainder; end
      end
      @(posedge clk); #1;
      if (c == first) begin bus.div_src1 = 32'd17; bus.div_src2 = 32'd5; end
      if (c == second) bus.div_start = 1'b0;
      #1;
      if (c == first) stall_acc = bus.div_stall;
    end
    bus.div_start = 1'b0;
    n_chk++; if (first !== 33) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 33", first); end
    n_chk++; if (second !== 67) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected 67", second); end
    n_chk++; if (ndone !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    n_chk++; if (stall_acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_stall: got %b expected 1", stall_acc); end
    n_chk++; if (q1 !== 32'd6 || r1 !== 32'd2) begin n_fail++; $display("FAIL b2b_first_result: got q=%h r=%h expected q=%h r=%h", q1, r1, 32'd6, 32'd2); end
    n_chk++; if (q2 !== 32'd3 || r2 !== 32'd2) begin n_fail++; $display("FAIL b2b_second_result: got q=%h r=%h expected q=%h r=%h", q2, r2, 32'd3, 32'd2); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage, directly downstream of the ID control decoder.
- Started by DIV/DIVU: the EX-stage ALU one-hot select bit 3 is set, and the ALU op2 flag is set for DIVU and clear for DIV.
- Stalls the pipeline while it computes.
- Delivers the quotient (to LO) and remainder (to HI) for the HI/LO write that the decoder's high/low write enables gate.

Parameters:
- WIDTH, 32, operand and result width in bits. Iteration count equals WIDTH.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; every state change happens on the rising edge.
- rst  input  1  synchronous active-high reset.
- div_start  input  1  a valid DIV/DIVU is in EX. Held high by the pipeline until div_done.
- div_signed  input  1  1 = DIV, 0 = DIVU. Driven as the inverse of the ALU op2 flag.
- div_src1  input  WIDTH  dividend (rs data).
- div_src2  input  WIDTH  divisor (rt data).
- div_flush  input  1  exception/ERET cancel of the EX instruction.
- div_stall  output  1  freeze IF/ID/EX.
- div_done  output  1  result valid this cycle; one-cycle pulse.
- div_quotient  output  WIDTH  quotient, for the LO write.
- div_remainder  output  WIDTH  remainder, for the HI write.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state -> IDLE, counter -> 0, all datapath registers -> 0.
  - div_quotient = 0, div_remainder = 0, div_done = 0.
  - div_stall = 0 in the cycle after reset; from then on it follows its combinational definition.
  - Reset mid-operation abandons the operation with no done pulse.
- States are IDLE, CALC and DONE.
- IDLE:
  - If div_start=1 and div_flush=0, latch the operands and go to CALC with counter = 0.
  - Operands are latched as magnitudes: when div_signed=1, any negative operand is two's-complement negated.
  - Also latch q_neg = s1^s2 and r_neg = s1, where s1 and s2 are the operand sign bits (both 0 when unsigned).
  - Latch a div_by_zero flag and the raw div_src1.
- CALC, one iteration per cycle:
  - Shift the partial remainder left by one, bringing in the next dividend MSB.
  - Trial-subtract the divisor in WIDTH+1 bits.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments each cycle. After WIDTH iterations (counter == WIDTH-1 at the edge) go to DONE.
- Result registers are loaded on the CALC->DONE edge:
  - Apply sign correction: negate the quotient if q_neg, negate the remainder if r_neg.
  - If div_by_zero: quotient = all ones, remainder = raw div_src1, regardless of sign.
  - Signed overflow (most-negative / -1) wraps: quotient = most-negative, remainder = 0.
- DONE:
  - div_done = 1 and div_stall = 0, so the stalled instruction advances.
  - Always returns to IDLE next cycle. div_start is ignored in DONE.
  - A back-to-back divide therefore starts in the following IDLE cycle.
- Stall and outputs:
  - div_stall = (IDLE & div_start & ~div_flush) | CALC. It is combinational, so it is high in the accept cycle.
  - Latency: accept at cycle 0, CALC in cycles 1..WIDTH, div_done at cycle WIDTH+1 (33 for WIDTH=32).
  - div_quotient and div_remainder hold their last values until the next CALC->DONE edge.
- Flush:
  - div_flush=1 in CALC forces IDLE at the next edge, with no done pulse and results unchanged.
  - div_stall is low in the flush cycle.
  - div_flush=1 in DONE does not alter div_done; the pipeline gates the HI/LO write.
  - div_flush=1 in IDLE blocks acceptance.
- div_start dropping during CALC without a flush is illegal. The unit ignores it and completes.

Test Plan:
- DIVU 100/7: start at cycle 0 -> stall high cycles 0..32, done at cycle 33, quotient = 14, remainder = 2.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. DIV 7/-2 -> quotient = 0xFFFFFFFD, remainder = 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0. DIVU 0xFFFFFFFF / 1 -> quotient = 0xFFFFFFFF, remainder = 0.
- Divide by zero, DIVU 5/0 and DIV -5/0 -> quotient = 0xFFFFFFFF, remainder = 0x00000005 and 0xFFFFFFFB respectively.
- Flush at cycle 10 of CALC -> no done pulse, stall low from cycle 10, outputs unchanged. A new DIVU 9/3 started at cycle 12 -> done at cycle 45, quotient = 3, remainder = 0.
- rst=1 at cycle 5 of CALC -> IDLE, quotient = remainder = 0, stall = 0. Back-to-back DIVs -> second accepted in the IDLE cycle after DONE, with no lost or duplicate done pulse.
